// File: rtl/operand_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_sequencer_if
// Description : Bundles the decode-issue, execute-operand, writeback and
//               register-file port signals of the operand fetch sequencer.
//               modport slave  : the sequencer's view.
//               modport master : the surrounding pipeline / register file.
// Ports       : issue_* (decode -> sequencer), op_* (sequencer -> execute),
//               wb_* (writeback -> sequencer), rf_* (sequencer <-> RF port).
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [IDX_W-1:0] issue_rs1;
    logic [IDX_W-1:0] issue_rs2;
    logic [IDX_W-1:0] issue_rd;
    logic             issue_rd_we;

    logic             op_valid;
    logic             op_ready;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [IDX_W-1:0] op_rd;
    logic             op_rd_we;

    logic             wb_valid;
    logic             wb_ready;
    logic [IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;

    logic [31:0]      rf_register;
    logic             rf_writeEnable;
    logic [XLEN-1:0]  rf_writeData;
    logic [XLEN-1:0]  rf_readData;

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
        output issue_ready,
        output op_valid, op_a, op_b, op_rd, op_rd_we,
        input  op_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_register, rf_writeEnable, rf_writeData,
        input  rf_readData
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
        input  issue_ready,
        input  op_valid, op_a, op_b, op_rd, op_rd_we,
        output op_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_register, rf_writeEnable, rf_writeData,
        output rf_readData
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_sequencer
// Description : Owns the single register-file port. Reads rs1 then rs2 of one
//               issued instruction, presents them to execute over valid/ready,
//               and arbitrates writebacks onto the same port with priority.
//               Accepted writebacks are forwarded into captured operands.
// Ports       : clk  - clock
//               rst  - synchronous active-low reset
//               bus  - operand_fetch_sequencer_if.slave (issue/op/wb/rf)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_sequencer #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    operand_fetch_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rs1;
    logic [IDX_W-1:0] r_rs2;
    logic [IDX_W-1:0] r_rd;
    logic             r_rd_we;
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    logic             r_op_valid;

    logic             w_wb_act;
    logic             w_wb_we;
    logic             w_issue_ready;
    logic [IDX_W-1:0] w_rd_idx;
    logic [XLEN-1:0]  w_rd_data;
    logic [IDX_W-1:0] w_rf_idx;

    // Writeback owns the port whenever it is requested; nothing is granted
    // while reset is held low.
    assign w_wb_act      = rst & bus.wb_valid;
    assign w_wb_we       = w_wb_act & (bus.wb_rd != '0);
    assign w_issue_ready = rst & (r_state == IDLE) & ~bus.wb_valid;

    // Read index for the current fetch cycle; x0 always reads as zero.
    assign w_rd_idx  = (r_state == RD1) ? r_rs1 : r_rs2;
    assign w_rd_data = (w_rd_idx == '0) ? '0 : bus.rf_readData;

    always_comb begin
        w_rf_idx = '0;
        if (w_wb_act) begin
            w_rf_idx = bus.wb_rd;
        end else if (rst && (r_state == RD1 || r_state == RD2)) begin
            w_rf_idx = w_rd_idx;
        end
    end

    assign bus.rf_register    = 32'(w_rf_idx);
    assign bus.rf_writeEnable = w_wb_we;
    assign bus.rf_writeData   = w_wb_act ? bus.wb_data : '0;
    assign bus.wb_ready       = w_wb_act;
    assign bus.issue_ready    = w_issue_ready;

    assign bus.op_valid = r_op_valid & rst;
    assign bus.op_a     = r_op_a;
    assign bus.op_b     = r_op_b;
    assign bus.op_rd    = r_rd;
    assign bus.op_rd_we = r_rd_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.issue_valid && w_issue_ready) begin
                        r_rs1   <= bus.issue_rs1;
                        r_rs2   <= bus.issue_rs2;
                        r_rd    <= bus.issue_rd;
                        r_rd_we <= bus.issue_rd_we;
                        r_state <= RD1;
                    end
                end
                RD1: begin
                    // A writeback stalls the read; the later read sees it.
                    if (!w_wb_act) begin
                        r_op_a  <= w_rd_data;
                        r_state <= RD2;
                    end
                end
                RD2: begin
                    if (w_wb_act) begin
                        // op_a is already captured, so it must be patched.
                        if (w_wb_we && bus.wb_rd == r_rs1) begin
                            r_op_a <= bus.wb_data;
                        end
                    end else begin
                        r_op_b     <= w_rd_data;
                        r_op_valid <= 1'b1;
                        r_state    <= OUT;
                    end
                end
                OUT: begin
                    if (w_wb_we && bus.wb_rd == r_rs1) begin
                        r_op_a <= bus.wb_data;
                    end
                    if (w_wb_we && bus.wb_rd == r_rs2) begin
                        r_op_b <= bus.wb_data;
                    end
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_sequencer
// Description : Self-checking bench. An architectural register array tracks
//               every accepted writeback; while operands are offered they must
//               equal the current architectural values of rs1/rs2, and
//               op_valid must rise one cycle after the second port cycle that
//               is free of writeback traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_sequencer;
    localparam int XLEN  = 32;
    localparam int IDX_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_fetch_sequencer_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus ();

    operand_fetch_sequencer #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file behind the shared port.
    logic [31:0] rf_mem [32];
    logic        rf_clr;
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (bus.rf_writeEnable) begin
            rf_mem[bus.rf_register[4:0]] <= bus.rf_writeData;
        end
    end
    assign bus.rf_readData = rf_mem[bus.rf_register[4:0]];

    logic [31:0] mdl [32];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] arch(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : mdl[r];
    endfunction

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb_port();
        check("wb_ready", 32'(bus.wb_ready), 32'(bus.wb_valid));
        check("rf_we", 32'(bus.rf_writeEnable), 32'(bus.wb_valid && bus.wb_rd != 5'd0));
        if (bus.wb_valid) begin
            check("rf_reg_wb", bus.rf_register, 32'(bus.wb_rd));
            check("rf_wdata", bus.rf_writeData, bus.wb_data);
        end
    endtask

    task automatic model_wb();
        if (bus.wb_valid && bus.wb_rd != 5'd0) mdl[bus.wb_rd] = bus.wb_data;
    endtask

    // One writeback while idle: port is taken, issue is refused.
    task automatic wb_idle(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        @(negedge clk);
        check_wb_port();
        check("issue_ready_wb", 32'(bus.issue_ready), 32'd0);
        model_wb();
        post_edge();
        bus.wb_valid = 1'b0;
    endtask

    // Issues one instruction and follows it to completion.
    // wb_pct: random writeback rate; hold: OUT cycles with op_ready low (<0 random);
    // fwb_cyc: cycle after acceptance at which a forced writeback occurs (<0 none).
    task automatic run_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic we,
                             input int wb_pct, input int hold, input int fwb_cyc,
                             input logic [4:0] f_rd, input logic [31:0] f_data);
        int reads, outc, cyc;
        bit done;
        bus.wb_valid    = 1'b0;
        bus.op_ready    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_rd    = rd;
        bus.issue_rd_we = we;
        @(negedge clk);
        check("issue_ready_idle", 32'(bus.issue_ready), 32'd1);
        check("op_valid_idle", 32'(bus.op_valid), 32'd0);
        post_edge();
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = 5'($urandom);
        bus.issue_rs2   = 5'($urandom);
        bus.issue_rd    = 5'($urandom);
        bus.issue_rd_we = 1'($urandom);
        reads = 0; outc = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            if (cyc == fwb_cyc) begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = f_rd;
                bus.wb_data  = f_data;
            end else begin
                bus.wb_valid = ($urandom_range(99) < wb_pct);
                case ($urandom_range(3))
                    0: bus.wb_rd = rs1;
                    1: bus.wb_rd = rs2;
                    2: bus.wb_rd = 5'd0;
                    default: bus.wb_rd = 5'($urandom_range(31));
                endcase
                bus.wb_data = $urandom;
            end
            if (reads == 2) bus.op_ready = (hold < 0) ? 1'($urandom_range(1)) : (outc >= hold);
            else            bus.op_ready = 1'($urandom_range(1));
            @(negedge clk);
            check_wb_port();
            check("issue_ready_busy", 32'(bus.issue_ready), 32'd0);
            if (reads < 2) begin
                check("op_valid_early", 32'(bus.op_valid), 32'd0);
            end else begin
                check("op_valid", 32'(bus.op_valid), 32'd1);
                check("op_a", bus.op_a, arch(rs1));
                check("op_b", bus.op_b, arch(rs2));
                check("op_rd", 32'(bus.op_rd), 32'(rd));
                check("op_rd_we", 32'(bus.op_rd_we), 32'(we));
            end
            model_wb();
            if (reads < 2) begin
                if (!bus.wb_valid) reads++;
            end else begin
                if (bus.op_ready) done = 1'b1;
                outc++;
            end
            post_edge();
            cyc++;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        bus.wb_valid = 1'b0;
        bus.op_ready = 1'b0;
        @(negedge clk);
        check("op_valid_after", 32'(bus.op_valid), 32'd0);
        check("issue_ready_after", 32'(bus.issue_ready), 32'd1);
        post_edge();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst = 1'b0;
        rf_clr = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.issue_rd = '0; bus.issue_rd_we = 1'b0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

        // Reset state, with a writeback and issue requested during reset.
        post_edge();
        post_edge();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h55;
        bus.issue_valid = 1'b1;
        @(negedge clk);
        check("rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        check("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
        check("rst_rf_we", 32'(bus.rf_writeEnable), 32'd0);
        check("rst_op_a", bus.op_a, 32'd0);
        check("rst_op_b", bus.op_b, 32'd0);
        check("rst_op_rd", 32'(bus.op_rd), 32'd0);
        post_edge();
        rst = 1'b1;
        rf_clr = 1'b0;
        bus.wb_valid = 1'b0;
        bus.issue_valid = 1'b0;

        // Preload and basic read.
        wb_idle(5'd10, 32'd4);
        wb_idle(5'd11, 32'd4);
        run_instr(5'd10, 5'd11, 5'd12, 1'b1, 0, 0, -1, 5'd0, 32'd0);

        // x0 write is accepted and dropped; x0 reads as zero.
        wb_idle(5'd0, 32'hDEADBEEF);
        run_instr(5'd0, 5'd10, 5'd3, 1'b0, 0, 2, -1, 5'd0, 32'd0);

        // Contention in RD1.
        run_instr(5'd10, 5'd11, 5'd12, 1'b1, 0, 0, 0, 5'd10, 32'd9);

        // Forwarding into op_b under 5 cycles of backpressure.
        run_instr(5'd10, 5'd11, 5'd12, 1'b1, 0, 5, 3, 5'd11, 32'd7);

        // Reset while in RD2.
        bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd10; bus.issue_rs2 = 5'd11;
        bus.issue_rd = 5'd5; bus.issue_rd_we = 1'b1;
        post_edge();
        bus.issue_valid = 1'b0;
        post_edge();
        rst = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h1234;
        @(negedge clk);
        check("mid_rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("mid_rst_rf_we", 32'(bus.rf_writeEnable), 32'd0);
        check("mid_rst_wb_ready", 32'(bus.wb_ready), 32'd0);
        post_edge();
        rst = 1'b1;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check("post_rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("post_rst_op_a", bus.op_a, 32'd0);
        check("post_rst_op_b", bus.op_b, 32'd0);
        check("post_rst_op_rd", 32'(bus.op_rd), 32'd0);
        check("post_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        post_edge();
        run_instr(5'd6, 5'd10, 5'd1, 1'b1, 0, 0, -1, 5'd0, 32'd0);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 40; n++) begin
            run_instr(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom),
                      1'($urandom), 35, -1, -1, 5'd0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
